// File: rtl/router_ctrl_fsm_pkg.sv
// Shared types and constants for the router write-side controller.
//   state_t       3-bit binary state encoding of the controller FSM
//   N_PORTS       number of output FIFOs (fixed at 3)
//   ADDR_W        width of the header address field
//   ADDR_INVALID  header address value that marks a packet to be dropped
//   port_bit()    selects one per-port flag by address; the invalid address reads 0
package router_ctrl_fsm_pkg;

  localparam int N_PORTS = 3;
  localparam int ADDR_W  = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DA  = 3'd0,  // DECODE_ADDRESS
    LFD = 3'd1,  // LOAD_FIRST_DATA
    LD  = 3'd2,  // LOAD_DATA
    FFS = 3'd3,  // FIFO_FULL_STATE
    LAF = 3'd4,  // LOAD_AFTER_FULL
    LP  = 3'd5,  // LOAD_PARITY
    CPE = 3'd6,  // CHECK_PARITY_ERROR
    WTE = 3'd7   // WAIT_TILL_EMPTY
  } state_t;

  function automatic logic port_bit(input logic [N_PORTS-1:0] flags,
                                    input logic [ADDR_W-1:0]  addr);
    logic sel;
    case (addr)
      2'd0:    sel = flags[0];
      2'd1:    sel = flags[1];
      2'd2:    sel = flags[2];
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Signal bundle between the router write-side controller and its neighbours
// (packet source, output FIFOs, sync stage and register stage).
//   master  - the controller: consumes source/FIFO/register status, drives state decodes
//   slave   - the environment: drives source/FIFO/register status, observes decodes
interface router_ctrl_fsm_if;
  import router_ctrl_fsm_pkg::*;

  // source side
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              busy;

  // FIFO / sync stage side
  logic              fifo_full;
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic              soft_reset_0;
  logic              soft_reset_1;
  logic              soft_reset_2;

  // register stage side
  logic              parity_done;
  logic              low_pkt_valid;

  // controller decodes
  logic [ADDR_W-1:0] port_sel;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              write_enb_reg;

  modport master (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output busy, port_sel, detect_add, lfd_state, ld_state, laf_state,
    output full_state, rst_int_reg, write_enb_reg
  );

  modport slave (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  busy, port_sel, detect_add, lfd_state, ld_state, laf_state,
    input  full_state, rst_int_reg, write_enb_reg
  );

endinterface

// File: rtl/router_ctrl_fsm.sv
// Upstream write-side controller of the 3-port router. Decodes the header
// address, latches the destination port, sequences header/payload/parity
// loads, stalls the source while the selected FIFO is full and aborts back to
// address decode when the selected port is soft-reset.
// Ports:
//   clock   system clock, all state updates on the rising edge
//   resetn  synchronous active-low reset
//   bus     router_ctrl_fsm_if.master (source, FIFO and register stage signals)
//
// state | meaning
// ------+-----------------------------------------------------------
// DA    | decode header address, latch destination port
// WTE   | destination FIFO not empty yet, hold the header
// LFD   | write header byte (one cycle)
// LD    | write payload bytes while the source keeps pkt_valid
// FFS   | selected FIFO full, stall
// LAF   | one write after the stall, then resume / finish
// LP    | write parity byte
// CPE   | parity check cycle, return to DA unless FIFO is full
module router_ctrl_fsm
  import router_ctrl_fsm_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  router_ctrl_fsm_if.master bus
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] port_sel_q, port_sel_next;
  logic [N_PORTS-1:0] empty_vec;
  logic [N_PORTS-1:0] soft_vec;
  logic              hdr_ok;

  assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign soft_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  assign hdr_ok    = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= DA;
      port_sel_q <= '0;
    end else begin
      state      <= state_next;
      port_sel_q <= port_sel_next;
    end
  end

  always_comb begin
    state_next    = state;
    port_sel_next = port_sel_q;
    case (state)
      DA: begin
        if (hdr_ok) begin
          port_sel_next = bus.data_in;
          // emptiness is looked up by the incoming address, not the stale latch
          state_next    = port_bit(empty_vec, bus.data_in) ? LFD : WTE;
        end
      end
      WTE: if (port_bit(empty_vec, port_sel_q)) state_next = LFD;
      LFD: state_next = LD;
      LD: begin
        if (bus.fifo_full)      state_next = FFS;
        else if (!bus.pkt_valid) state_next = LP;
      end
      FFS: if (!bus.fifo_full) state_next = LAF;
      LAF: begin
        if (bus.parity_done)        state_next = DA;
        else if (bus.low_pkt_valid) state_next = LP;
        else                        state_next = LD;
      end
      LP:  state_next = CPE;
      CPE: state_next = bus.fifo_full ? FFS : DA;
      default: state_next = DA;
    endcase

    // a timed-out selected port abandons the packet from any active state
    if ((state != DA) && port_bit(soft_vec, port_sel_q)) state_next = DA;
  end

  always_comb begin
    bus.port_sel      = port_sel_q;
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.busy          = 1'b1;
    case (state)
      DA:  begin bus.detect_add = 1'b1; bus.busy = 1'b0; end
      LFD: bus.lfd_state = 1'b1;
      LD:  begin bus.ld_state = 1'b1; bus.write_enb_reg = 1'b1; bus.busy = 1'b0; end
      FFS: bus.full_state = 1'b1;
      LAF: begin bus.laf_state = 1'b1; bus.write_enb_reg = 1'b1; end
      LP:  bus.write_enb_reg = 1'b1;
      CPE: bus.rst_int_reg = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm. Each scenario pushes the expected
// output vector when it drives a cycle; the sampled DUT vector is queued after
// the edge and each scenario drains and compares both queues.
module tb_router_ctrl_fsm;
  import router_ctrl_fsm_pkg::*;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;

  // {port_sel[1:0], detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  router_ctrl_fsm_if bus();

  router_ctrl_fsm dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] exp_of(input state_t st, input logic [1:0] ps);
    logic [9:0] v;
    v[9:8] = ps;
    v[7]   = (st == DA);
    v[6]   = (st == LFD);
    v[5]   = (st == LD);
    v[4]   = (st == LAF);
    v[3]   = (st == FFS);
    v[2]   = (st == CPE);
    v[1]   = (st == LD) || (st == LAF) || (st == LP);
    v[0]   = !((st == DA) || (st == LD));
    return v;
  endfunction

  // push the expectation for the state reached at the next edge, then sample
  task automatic step(input state_t st, input logic [1:0] ps);
    exp_q.push_back(exp_of(st, ps));
    @(posedge clock);
    #1;
    obs_q.push_back({bus.port_sel, bus.detect_add, bus.lfd_state, bus.ld_state,
                     bus.laf_state, bus.full_state, bus.rst_int_reg,
                     bus.write_enb_reg, bus.busy});
  endtask

  task automatic idle_inputs();
    bus.pkt_valid = 1'b0; bus.data_in = 2'd0; bus.fifo_full = 1'b0;
    bus.fifo_empty_0 = 1'b0; bus.fifo_empty_1 = 1'b0; bus.fifo_empty_2 = 1'b0;
    bus.soft_reset_0 = 1'b0; bus.soft_reset_1 = 1'b0; bus.soft_reset_2 = 1'b0;
    bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] e, o;
    idle_inputs();
    resetn = 1'b0;
    step(DA, 2'd0);
    step(DA, 2'd0);
    resetn = 1'b1;
    step(DA, 2'd0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_normal();
    logic [9:0] e, o;
    bus.pkt_valid = 1'b1; bus.data_in = 2'd1; bus.fifo_empty_1 = 1'b1;
    step(LFD, 2'd1);
    bus.data_in = 2'd0;  // payload bytes must not disturb the latched port
    step(LD, 2'd1);
    step(LD, 2'd1);
    bus.pkt_valid = 1'b0;
    step(LP, 2'd1);
    step(CPE, 2'd1);
    step(DA, 2'd1);
    step(DA, 2'd1);
    bus.fifo_empty_1 = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL normal[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_wait_empty();
    logic [9:0] e, o;
    bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b0;
    bus.fifo_empty_0 = 1'b1;  // another port empty must not release WTE
    step(WTE, 2'd2);
    for (int k = 0; k < 5; k++) step(WTE, 2'd2);
    bus.fifo_empty_2 = 1'b1;
    step(LFD, 2'd2);
    step(LD, 2'd2);
    bus.pkt_valid = 1'b0;
    step(LP, 2'd2);
    step(CPE, 2'd2);
    step(DA, 2'd2);
    bus.fifo_empty_2 = 1'b0; bus.fifo_empty_0 = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL wait_empty[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_full_stall();
    logic [9:0] e, o;
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0; bus.fifo_empty_0 = 1'b1;
    step(LFD, 2'd0);
    step(LD, 2'd0);
    bus.fifo_full = 1'b1;
    step(FFS, 2'd0);
    step(FFS, 2'd0);
    bus.fifo_full = 1'b0;
    step(LAF, 2'd0);
    step(LD, 2'd0);             // LAF with neither flag resumes payload
    bus.fifo_full = 1'b1;
    bus.pkt_valid = 1'b0;       // fifo_full beats !pkt_valid in LD
    step(FFS, 2'd0);
    bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1;
    step(LAF, 2'd0);
    step(LP, 2'd0);
    bus.low_pkt_valid = 1'b0; bus.fifo_full = 1'b1;
    step(CPE, 2'd0);
    step(FFS, 2'd0);            // CPE with full FIFO goes back to stall
    bus.fifo_full = 1'b0; bus.parity_done = 1'b1; bus.low_pkt_valid = 1'b1;
    step(LAF, 2'd0);
    step(DA, 2'd0);             // parity_done beats low_pkt_valid
    bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0;
    step(DA, 2'd0);
    bus.fifo_empty_0 = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL full_stall[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_soft_reset();
    logic [9:0] e, o;
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0; bus.fifo_empty_0 = 1'b1;
    bus.soft_reset_0 = 1'b1;    // no effect while in DA
    step(LFD, 2'd0);
    step(DA, 2'd0);             // selected port soft reset overrides LFD->LD
    bus.soft_reset_0 = 1'b0;
    step(LFD, 2'd0);
    step(LD, 2'd0);
    bus.soft_reset_1 = 1'b1; bus.soft_reset_2 = 1'b1;
    step(LD, 2'd0);
    bus.soft_reset_1 = 1'b0; bus.soft_reset_2 = 1'b0;
    bus.soft_reset_0 = 1'b1; bus.pkt_valid = 1'b0;
    step(DA, 2'd0);
    bus.soft_reset_0 = 1'b0;
    step(DA, 2'd0);
    bus.fifo_empty_0 = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL soft_reset[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_invalid_and_midreset();
    logic [9:0] e, o;
    // latch port 2 first so a dropped header visibly leaves it alone
    bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b1;
    step(LFD, 2'd2);
    bus.soft_reset_2 = 1'b1;
    step(DA, 2'd2);
    bus.soft_reset_2 = 1'b0;
    bus.data_in = 2'd3; bus.fifo_empty_0 = 1'b1; bus.fifo_empty_1 = 1'b1;
    step(DA, 2'd2);
    step(DA, 2'd2);
    bus.data_in = 2'd1;
    step(LFD, 2'd1);
    step(LD, 2'd1);
    bus.fifo_full = 1'b1;
    step(FFS, 2'd1);
    resetn = 1'b0;
    step(DA, 2'd0);
    resetn = 1'b1; bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
    step(DA, 2'd0);
    // back-to-back: a new header straight after returning to DA
    bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
    step(LFD, 2'd1);
    bus.pkt_valid = 1'b0;
    step(LD, 2'd1);
    step(LP, 2'd1);
    step(CPE, 2'd1);
    step(DA, 2'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL invalid_midreset[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_wait_empty();
    test_full_stall();
    test_soft_reset();
    test_invalid_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
